hit_judge: RTL and testbench
============================

// Module: hit_judge
// PURPOSE
//  Player-input end of the note lanes: the renderer draws falling notes, this block
//  reads the drum pads and judges each strike against each lane's note Y position.
//  Outputs score, miss count and the `perdio` flag consumed by the level FSM.
//  Sits beside the Tubo lanes: note_y comes from their posicionYS, and enable is comenzar.
// PARAMETERS
//  LANES      5      number of drum pads / note lanes
//  YW         10     width of a lane Y coordinate (matches pixel_y)
//  HIT_TOP    368    first Y (inclusive) of the hit window
//  HIT_BOT    400    last Y (inclusive) of the hit window
//  DB_CYC     250000 cycles a pad must be stable before its level is accepted
//  MISS_LIMIT 8      number of misses that forces perdio
//  SW         12     score counter width
// PORTS
//  clk        in  1        system clock, single domain
//  reset      in  1        asynchronous, active-low reset
//  enable     in  1        game running (comenzar); 0 freezes judging, counters hold
//  boton      in  LANES    raw pad inputs, asynchronous, active-high
//  note_y     in  LANES*YW packed note Y per lane; lane i = note_y[i*YW +: YW]
//  note_vld   in  LANES    lane i currently has a note on screen
//  score      out SW       saturating hit counter
//  misses     out 4        saturating miss counter
//  hit_pulse  out LANES    1-cycle pulse per lane on a judged hit
//  miss_pulse out LANES    1-cycle pulse per lane on a judged miss
//  perdio     out 1        sticky lose flag
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; synchronisers 0; lane FSMs in IDLE.
//  Input path per lane: 2-FF synchroniser, then a debouncer. The debouncer accepts a
//   new level after DB_CYC identical consecutive samples. A rising edge of the accepted
//   level gives a 1-cycle press. Latency from a stable pad to press is 2+DB_CYC+1 cycles.
//  in_win(i) = note_vld[i] && HIT_TOP <= y_i <= HIT_BOT (unsigned YW compares).
//  Lane FSM, 3 states, evaluated only when enable=1:
//   IDLE   : in_win -> ARMED; press -> miss (wrong strike), stay IDLE
//   ARMED  : press -> hit, go DONE; y_i>HIT_BOT or !note_vld -> miss, go IDLE
//   DONE   : stays until !in_win (note leaves window or vanishes), then IDLE;
//            a press in DONE -> miss (double strike)
//  hit/miss pulses are registered: they appear one cycle after the press or exit event.
//  Counting: score += popcount(hit_pulse) each cycle, saturating at 2^SW-1. misses +=
//   popcount(miss_pulse), saturating at 15. Several lanes in the same cycle all count.
//  perdio: set in the cycle after misses >= MISS_LIMIT; held until reset. While
//   perdio=1 no further pulses are produced and the counters hold.
//  enable=0: FSMs hold state, pulses are forced to 0, and the debouncers keep running.
//   A press during enable=0 is discarded and is not queued.
//  A press and a window exit in the same cycle while ARMED count as a hit, not a miss.
//  Reset asserted mid-game clears everything immediately, including perdio.
// STRUCTURE
//  Shared include drum_defs.vh: LANES, YW, HIT_TOP, HIT_BOT, and the FSM state
//   encodings (IDLE=2'd0, ARMED=2'd1, DONE=2'd2). These are shared with the Tubo lanes.
//  One sub-module pad_debounce (synchroniser + stable counter + edge detect),
//   instantiated LANES times via generate. The lane FSMs and counters live in hit_judge.
// TESTING (sim with DB_CYC=4)
//  1 reset=0 mid-run, with misses=3 and perdio=0 -> all outputs 0 asynchronously.
//  2 lane0 y steps 360..410, pad0 held 10 cycles at y=384 -> hit_pulse[0] once, score=1.
//  3 lane2 y passes 368..401 with no press -> miss_pulse[2] once at y=401, misses=1.
//  4 pads 0,1,3 pressed together, all in window -> score +3 in one cycle.
//  5 pad4 pressed with note_vld[4]=0, 8 times -> misses=8, perdio=1; further hits
//    produce no pulse.
//  6 pad bounce 1-0-1 within 3 cycles -> no press; enable=0 during a press -> no pulse.

Source files
------------

// File: rtl/hit_judge_pkg.sv
// ----------------------------------------------------------------------------
// hit_judge_pkg
//   Shared lane geometry, lane state encoding and small helper functions.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hit_judge_pkg;

  localparam int LANES   = 5;
  localparam int YW      = 10;
  localparam int HIT_TOP = 368;
  localparam int HIT_BOT = 400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } lane_state_t;

  function automatic logic in_window(input logic [YW-1:0] y, input logic vld);
    return vld && (y >= YW'(HIT_TOP)) && (y <= YW'(HIT_BOT));
  endfunction

  function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hit_judge_pad_debounce.sv
// ----------------------------------------------------------------------------
// hit_judge_pad_debounce
//   Two-flop synchroniser, stable-level debouncer and rising-edge press pulse.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hit_judge_pad_debounce #(
  parameter int DB_CYC = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic press
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive synchronised samples that disagree with r_level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= pad;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYC - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/hit_judge.sv
// ----------------------------------------------------------------------------
// hit_judge
//   Judges debounced drum-pad strikes against each lane's note position.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int DB_CYC     = 250000,
  parameter int MISS_LIMIT = 8,
  parameter int SW         = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LANES-1:0]      boton,
  input  logic [LANES*YW-1:0]   note_y,
  input  logic [LANES-1:0]      note_vld,
  output logic [SW-1:0]         score,
  output logic [3:0]            misses,
  output logic [LANES-1:0]      hit_pulse,
  output logic [LANES-1:0]      miss_pulse,
  output logic                  perdio
);

  logic [LANES-1:0] w_press;
  logic [YW-1:0]    w_y [LANES];
  logic [LANES-1:0] w_win;
  logic [LANES-1:0] w_hit;
  logic [LANES-1:0] w_miss;
  logic             w_active;
  lane_state_t      r_state     [LANES];
  lane_state_t      w_state_nxt [LANES];
  logic [LANES-1:0] r_hit;
  logic [LANES-1:0] r_miss;
  logic [SW-1:0]    r_score;
  logic [3:0]       r_misses;
  logic             r_perdio;
  logic [SW:0]      w_score_sum;
  logic [4:0]       w_miss_sum;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_pad
      hit_judge_pad_debounce #(
        .DB_CYC (DB_CYC)
      ) u_pad (
        .clk   (clk),
        .reset (reset),
        .pad   (boton[gi]),
        .press (w_press[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_y[i]   = note_y[i*YW +: YW];
      w_win[i] = in_window(w_y[i], note_vld[i]);
    end
  end

  // Lanes freeze as soon as the limit is reached so no pulse outlives the loss
  assign w_active = enable && !r_perdio && (r_misses < 4'(MISS_LIMIT));

  always_comb begin
    w_hit  = '0;
    w_miss = '0;
    for (int i = 0; i < LANES; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_active) begin
        case (r_state[i])
          IDLE: begin
            if (w_press[i]) begin
              w_miss[i] = 1'b1;
            end else if (w_win[i]) begin
              w_state_nxt[i] = ARMED;
            end
          end
          ARMED: begin
            if (w_press[i]) begin
              w_hit[i]       = 1'b1;
              w_state_nxt[i] = DONE;
            end else if ((w_y[i] > YW'(HIT_BOT)) || !note_vld[i]) begin
              w_miss[i]      = 1'b1;
              w_state_nxt[i] = IDLE;
            end
          end
          DONE: begin
            if (w_press[i]) begin
              w_miss[i] = 1'b1;
            end
            if (!w_win[i]) begin
              w_state_nxt[i] = IDLE;
            end
          end
          default: w_state_nxt[i] = IDLE;
        endcase
      end
    end
  end

  assign w_score_sum = {1'b0, r_score} + (SW+1)'(popcount(r_hit));
  assign w_miss_sum  = {1'b0, r_misses} + {1'b0, popcount(r_miss)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        r_state[i] <= IDLE;
      end
      r_hit    <= '0;
      r_miss   <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_perdio <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
      r_hit    <= w_hit;
      r_miss   <= w_miss;
      r_score  <= w_score_sum[SW] ? '1 : w_score_sum[SW-1:0];
      r_misses <= (w_miss_sum > 5'd15) ? 4'hF : w_miss_sum[3:0];
      r_perdio <= r_perdio || (r_misses >= 4'(MISS_LIMIT));
    end
  end

  assign score      = r_score;
  assign misses     = r_misses;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;
  assign perdio     = r_perdio;

endmodule

`default_nettype wire

// File: tb/tb_hit_judge.sv
// ----------------------------------------------------------------------------
// tb_hit_judge
//   Self-checking bench for hit_judge: vector table, directed corners, random.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hit_judge;
  import hit_judge_pkg::*;

  localparam int DB = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [LANES-1:0]    boton;
  logic [LANES*YW-1:0] note_y;
  logic [LANES-1:0]    note_vld;
  logic [11:0]         score;
  logic [3:0]          misses;
  logic [LANES-1:0]    hit_pulse;
  logic [LANES-1:0]    miss_pulse;
  logic                perdio;

  int checks = 0;
  int errors = 0;

  hit_judge #(.DB_CYC(DB), .MISS_LIMIT(8), .SW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .boton      (boton),
    .note_y     (note_y),
    .note_vld   (note_vld),
    .score      (score),
    .misses     (misses),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .perdio     (perdio)
  );

  always #5 clk = ~clk;

  // Reference model: behavioural view of each pad and lane
  localparam int WAIT = 0, LIVE = 1, JUDGED = 2;
  bit   m_s1 [LANES], m_s2 [LANES], m_last [LANES], m_acc [LANES], m_accd [LANES], m_press [LANES];
  int   m_run [LANES], m_stage [LANES];
  bit [LANES-1:0] m_hit, m_miss;
  int   m_score, m_misses;
  bit   m_lost;
  int   seen_hit [LANES], seen_miss [LANES];
  int   max_hits_once;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_last[i] = 0; m_acc[i] = 0; m_accd[i] = 0;
      m_press[i] = 0; m_run[i] = 0; m_stage[i] = WAIT;
    end
    m_hit = '0; m_miss = '0; m_score = 0; m_misses = 0; m_lost = 0;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < LANES; i++) begin
      seen_hit[i] = 0; seen_miss[i] = 0;
    end
    max_hits_once = 0;
  endtask

  task automatic model_edge();
    int y;
    bit win, smp, active;
    bit [LANES-1:0] nhit, nmiss;
    active  = enable && !m_lost && (m_misses < 8);
    m_lost  = m_lost || (m_misses >= 8);
    m_score = m_score + $countones(m_hit);
    if (m_score > 4095) m_score = 4095;
    m_misses = m_misses + $countones(m_miss);
    if (m_misses > 15) m_misses = 15;
    nhit = '0; nmiss = '0;
    for (int i = 0; i < LANES; i++) begin
      y   = int'(note_y[i*YW +: YW]);
      win = note_vld[i] && (y >= 368) && (y <= 400);
      if (active) begin
        if (m_stage[i] == WAIT) begin
          if (m_press[i]) nmiss[i] = 1;
          else if (win) m_stage[i] = LIVE;
        end else if (m_stage[i] == LIVE) begin
          if (m_press[i]) begin nhit[i] = 1; m_stage[i] = JUDGED; end
          else if (y > 400 || !note_vld[i]) begin nmiss[i] = 1; m_stage[i] = WAIT; end
        end else begin
          if (m_press[i]) nmiss[i] = 1;
          if (!win) m_stage[i] = WAIT;
        end
      end
      // pad pipeline: two sync stages, run-length acceptance, edge
      m_press[i] = m_acc[i] && !m_accd[i];
      m_accd[i]  = m_acc[i];
      smp = m_s2[i];
      if (smp == m_last[i]) begin
        if (m_run[i] < 1000) m_run[i]++;
      end else begin
        m_last[i] = smp; m_run[i] = 1;
      end
      if (m_last[i] != m_acc[i] && m_run[i] >= DB) m_acc[i] = m_last[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = boton[i];
    end
    m_hit = nhit; m_miss = nmiss;
  endtask

  task automatic compare_all();
    check("score", int'(score), m_score);
    check("misses", int'(misses), m_misses);
    check("hit_pulse", int'(hit_pulse), int'(m_hit));
    check("miss_pulse", int'(miss_pulse), int'(m_miss));
    check("perdio", int'(perdio), int'(m_lost));
  endtask

  // Inputs are set at a negedge; model advances, clock edge, compare next negedge
  task automatic step();
    model_edge();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < LANES; i++) begin
      seen_hit[i]  += int'(hit_pulse[i]);
      seen_miss[i] += int'(miss_pulse[i]);
    end
    if ($countones(hit_pulse) > max_hits_once) max_hits_once = $countones(hit_pulse);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
  endtask

  task automatic set_y(input int lane, input int y);
    note_y[lane*YW +: YW] = YW'(y);
  endtask

  task automatic press_pad(input logic [LANES-1:0] mask);
    boton = boton | mask;
    repeat (8) step();
    boton = boton & ~mask;
    repeat (8) step();
  endtask

  typedef struct {
    logic [LANES-1:0] press;
    int               y;
    logic [LANES-1:0] vld;
    int               exp_score;
    int               exp_misses;
  } vec_t;

  vec_t vecs [8];
  int   ry [LANES];
  int   lost_cyc;

  initial begin
    vecs[0] = '{5'b00001, 368, 5'b11111, 1, 4};
    vecs[1] = '{5'b11111, 400, 5'b11111, 5, 0};
    vecs[2] = '{5'b11111, 367, 5'b11111, 0, 5};
    vecs[3] = '{5'b11111, 401, 5'b11111, 0, 5};
    vecs[4] = '{5'b00000, 384, 5'b10101, 0, 3};
    vecs[5] = '{5'b00110, 390, 5'b00100, 1, 1};
    vecs[6] = '{5'b10000, 384, 5'b00000, 0, 1};
    vecs[7] = '{5'b00000, 500, 5'b11111, 0, 0};

    reset = 1'b0; enable = 1'b1; boton = '0; note_y = '0; note_vld = '0;
    model_clear();
    clear_seen();
    apply_reset();

    // Vector table: window edges, wrong strikes, unpressed armed lanes
    for (int v = 0; v < 8; v++) begin
      apply_reset();
      for (int i = 0; i < LANES; i++) set_y(i, vecs[v].y);
      note_vld = vecs[v].vld;
      repeat (2) step();
      press_pad(vecs[v].press);
      note_vld = '0;
      repeat (3) step();
      check($sformatf("vec%0d_score", v), int'(score), vecs[v].exp_score);
      check($sformatf("vec%0d_misses", v), int'(misses), vecs[v].exp_misses);
    end

    // Lane 0 note sweeps through the window with a held pad
    apply_reset();
    clear_seen();
    note_vld[0] = 1'b1;
    for (int y = 360; y <= 410; y++) begin
      set_y(0, y);
      if (y == 384) boton[0] = 1'b1;
      if (y == 394) boton[0] = 1'b0;
      step();
    end
    note_vld[0] = 1'b0;
    repeat (2) step();
    check("sweep_hits", seen_hit[0], 1);
    check("sweep_score", int'(score), 1);
    check("sweep_misses", int'(misses), 0);

    // Lane 2 passes the window untouched
    clear_seen();
    note_vld[2] = 1'b1;
    for (int y = 368; y <= 401; y++) begin
      set_y(2, y);
      step();
      if (y == 401) check("exit_miss_at_401", int'(miss_pulse[2]), 1);
    end
    note_vld[2] = 1'b0;
    repeat (2) step();
    check("exit_miss_count", seen_miss[2], 1);
    check("exit_misses", int'(misses), 1);

    // Three simultaneous hits
    clear_seen();
    for (int i = 0; i < LANES; i++) set_y(i, 380);
    note_vld = 5'b01011;
    repeat (2) step();
    press_pad(5'b01011);
    note_vld = '0;
    repeat (2) step();
    check("multi_hit_same_cycle", max_hits_once, 3);
    check("multi_hit_score", int'(score), 4);

    // Two wrong strikes, then an asynchronous reset between clock edges
    press_pad(5'b10000);
    press_pad(5'b10000);
    check("pre_reset_misses", int'(misses), 3);
    check("pre_reset_perdio", int'(perdio), 0);
    #2 reset = 1'b0;
    #1;
    check("async_score", int'(score), 0);
    check("async_misses", int'(misses), 0);
    check("async_perdio", int'(perdio), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;

    // Eight wrong strikes reach the loss limit
    for (int k = 0; k < 8; k++) press_pad(5'b10000);
    check("lose_misses", int'(misses), 8);
    check("lose_perdio", int'(perdio), 1);
    clear_seen();
    set_y(0, 380);
    note_vld[0] = 1'b1;
    repeat (2) step();
    press_pad(5'b00001);
    check("lost_no_hit", seen_hit[0], 0);
    check("lost_score_hold", int'(score), 0);
    note_vld = '0;

    // Bouncing pad and a press while disabled
    apply_reset();
    clear_seen();
    set_y(0, 380);
    note_vld[0] = 1'b1;
    repeat (2) step();
    boton[0] = 1'b1; step();
    boton[0] = 1'b0; step();
    boton[0] = 1'b1; step();
    boton[0] = 1'b0;
    repeat (10) step();
    check("bounce_no_hit", seen_hit[0], 0);
    check("bounce_no_miss", seen_miss[0], 0);
    enable = 1'b0;
    press_pad(5'b00001);
    enable = 1'b1;
    repeat (10) step();
    check("disabled_no_hit", seen_hit[0], 0);
    check("disabled_score", int'(score), 0);
    note_vld = '0;
    step();

    // Random traffic against the model
    apply_reset();
    for (int i = 0; i < LANES; i++) begin
      ry[i] = 355 + int'($urandom_range(0, 40));
      set_y(i, ry[i]);
    end
    note_vld = '1;
    lost_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < LANES; i++) begin
        ry[i] += int'($urandom_range(0, 2));
        if (ry[i] > 415) begin
          ry[i] = 355 + int'($urandom_range(0, 10));
          note_vld[i] = ($urandom_range(0, 3) != 0);
        end
        set_y(i, ry[i]);
        if ($urandom_range(0, 59) == 0) note_vld[i] = ~note_vld[i];
        if ($urandom_range(0, 9) == 0) boton[i] = ~boton[i];
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      step();
      if (perdio) lost_cyc++;
      if (lost_cyc > 40) begin
        apply_reset();
        lost_cyc = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
